execute_stage: RTL
==================

Name: execute_stage

Overview:
- Execute stage of the five-stage 16-bit pipeline.
- Takes decoded operands and control from the ID/EX buffer, runs the ALU and updates the flag register.
- Registers results and control into the EX/MEM buffer consumed directly by the memory stage.
- Owns the interrupt push sequencer: drives the counter value and select that the memory stage uses to push PC high, PC low and flags onto the stack.

Parameters:
- DATA_W, 16, datapath width
- PC_W, 32, program counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- Rsrc_value  in  16  source operand
- Rdst_value  in  16  destination operand
- imm  in  16  immediate / shift amount (low 4 bits used for shifts)
- Rdst_address  in  3  destination register index
- aluOp  in  4  ALU operation code
- memRead, memWrite, WB, push, pop  in  1 each  ID/EX control bits
- pc_in  in  32  PC of the instruction in EX
- flush  in  1  turn the current EX slot into a bubble
- irq  in  1  interrupt request (level)
- EXMEM_ALU_result  out  16  registered ALU result
- EXMEM_Rsrc_value  out  16  registered Rsrc
- EXMEM_Rdst_value  out  16  registered Rdst
- EXMEM_Rdst_address  out  3  registered destination index
- EXMEM_memRead, EXMEM_memWrite, EXMEM_WB, EXMEM_push, EXMEM_pop  out  1 each  registered control
- EXMEM_pc  out  32  PC captured at interrupt entry
- flagReg  out  16  bit0 Z, bit1 N, bit2 C, bits 15:3 always 0
- intCounterValue  out  2  push slot selector for memory stage
- intSignalFromCounter  out  1  interrupt push in progress
- stall  out  1  freeze upstream stages

Behaviour:
- Reset: rst is synchronous and active-high.
  - All EXMEM_* outputs, flagReg and intCounterValue reset to 0.
  - intSignalFromCounter=0, stall=0, FSM=IDLE.
  - A reset asserted mid-sequence aborts the sequence with no further pushes.
- ALU ops (combinational; result registered, 1-cycle latency):
  - 0 NOP: pass Rdst, no flag change
  - 1 NOT Rdst
  - 2 INC Rdst
  - 3 DEC Rdst
  - 4 ADD Rdst+Rsrc
  - 5 SUB Rdst-Rsrc
  - 6 AND
  - 7 OR
  - 8 SHL Rsrc by imm[3:0]
  - 9 SHR Rsrc by imm[3:0] (logical)
  - 10 MOV: pass Rsrc, no flag change
  - 11 SETC: C=1
  - 12 CLRC: C=0
  - 13 LDM: pass imm, no flag change
  - 14–15: treated as NOP
- Arithmetic: 17-bit internal sum. C is updated as follows:
  - ADD, INC: C = carry-out
  - SUB, DEC: C = borrow (1 when the unsigned result underflows)
  - SHL: C = last bit shifted out
  - SHR: C = last bit shifted out
  - Shift amount 0: C unchanged
- Z and N come from the 16-bit result for ops 1–9. C is unchanged for NOT, AND and OR.
- Flags update on the same edge the result is registered.
- flush=1 in IDLE: at the next edge all EXMEM control bits = 0 and data outputs are don't-care. Flags are not updated.
- FSM states: IDLE, PUSH_PCH, PUSH_PCL, PUSH_FLG.
  - IDLE with irq=1 and flush=0:
    - The instruction currently in EX completes normally on this edge.
    - EXMEM_pc <= pc_in + 1.
    - Next state is PUSH_PCH.
  - irq with flush=1: entry is deferred to the next IDLE cycle with flush=0.
  - In PUSH_PCH, PUSH_PCL and PUSH_FLG:
    - EXMEM registers are loaded with push=1, memWrite=1, memRead=0, pop=0, WB=0.
    - intSignalFromCounter=1.
    - intCounterValue = 01, 10, 11 respectively.
    - Data operands are held. Flags are frozen.
  - Transitions PUSH_PCH→PUSH_PCL→PUSH_FLG→IDLE are unconditional, one per cycle. After PUSH_FLG, intSignalFromCounter returns to 0.
  - irq is ignored outside IDLE; a new sequence may start on the first IDLE cycle.
- stall: combinational.
  - 1 in IDLE when an irq entry is taken, and in PUSH_PCH and PUSH_PCL. Upstream holds for exactly 3 cycles per interrupt.
  - 0 in PUSH_FLG, so upstream resumes on the edge PUSH_FLG→IDLE.
- Priority: rst > interrupt sequence > flush > normal.

Test Plan:
- Reset: apply rst with random inputs → all outputs 0, flagReg=0x0000, stall=0.
- ADD carry: Rdst=0xFFFF, Rsrc=0x0001, aluOp=4, WB=1 → next edge EXMEM_ALU_result=0x0000, flagReg=0x0005 (Z=1, C=1), EXMEM_WB=1.
- SUB and shift:
  - Rdst=0x0003, Rsrc=0x0005, aluOp=5 → result 0xFFFE, flagReg=0x0006 (N, C).
  - SHL Rsrc=0x8001 by imm=1 → result 0x0002, C=1.
- Interrupt: pc_in=0x00010020 with irq pulse in IDLE.
  - Following 3 cycles: intCounterValue 01, 10, 11 with EXMEM_push=1, EXMEM_memWrite=1, EXMEM_WB=0, EXMEM_pc=0x00010021.
  - stall high for exactly 3 cycles. Flags unchanged.
- Flush: aluOp=4 with WB=1, flush=1 → EXMEM_WB=0, EXMEM_memWrite=0, flagReg unchanged.
- Reset mid-interrupt: rst asserted in PUSH_PCL → next edge intSignalFromCounter=0, EXMEM_push=0, stall=0, FSM IDLE.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage: ALU + flag register, EX/MEM buffer, interrupt push sequencer.
// Latency: ALU result, flags and control registered one cycle after ID/EX inputs.
// Backpressure: stall freezes upstream for 3 cycles per interrupt (entry, PUSH_PCH, PUSH_PCL).
module execute_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Rsrc_value,
  input  logic [DATA_W-1:0] Rdst_value,
  input  logic [DATA_W-1:0] imm,
  input  logic [2:0]        Rdst_address,
  input  logic [3:0]        aluOp,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              WB,
  input  logic              push,
  input  logic              pop,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              flush,
  input  logic              irq,
  output logic [DATA_W-1:0] EXMEM_ALU_result,
  output logic [DATA_W-1:0] EXMEM_Rsrc_value,
  output logic [DATA_W-1:0] EXMEM_Rdst_value,
  output logic [2:0]        EXMEM_Rdst_address,
  output logic              EXMEM_memRead,
  output logic              EXMEM_memWrite,
  output logic              EXMEM_WB,
  output logic              EXMEM_push,
  output logic              EXMEM_pop,
  output logic [PC_W-1:0]   EXMEM_pc,
  output logic [DATA_W-1:0] flagReg,
  output logic [1:0]        intCounterValue,
  output logic              intSignalFromCounter,
  output logic              stall
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PUSH_PCH = 2'd1,
    PUSH_PCL = 2'd2,
    PUSH_FLG = 2'd3
  } state_t;

  state_t state;

  logic              zFlag, nFlag, cFlag;
  logic [DATA_W-1:0] aluRes;
  logic              zNext, nNext, cNext, updZN;
  logic [DATA_W:0]   incSum, decDiff, addSum, subDiff, shlWide, shrWide;
  logic [3:0]        shAmt;
  logic              irqTake;

  // Carry/borrow land in the extra top bit of each 17-bit result.
  assign shAmt   = imm[3:0];
  assign incSum  = {1'b0, Rdst_value} + {{DATA_W{1'b0}}, 1'b1};
  assign decDiff = {1'b0, Rdst_value} - {{DATA_W{1'b0}}, 1'b1};
  assign addSum  = {1'b0, Rdst_value} + {1'b0, Rsrc_value};
  assign subDiff = {1'b0, Rdst_value} - {1'b0, Rsrc_value};
  // Shift left: bit DATA_W holds the last bit shifted out.
  assign shlWide = {1'b0, Rsrc_value} << shAmt;
  // Shift right: bit 0 holds the last bit shifted out.
  assign shrWide = {Rsrc_value, 1'b0} >> shAmt;

  assign flagReg = {{(DATA_W-3){1'b0}}, cFlag, nFlag, zFlag};

  // An interrupt is only accepted from IDLE on a non-flushed cycle.
  assign irqTake = (state == IDLE) && irq && !flush;
  assign stall   = !rst && (irqTake || (state == PUSH_PCH) || (state == PUSH_PCL));

  // ALU datapath and next-flag computation.
  always_comb begin
    aluRes = Rdst_value;
    cNext  = cFlag;
    updZN  = 1'b0;
    case (aluOp)
      4'd1: begin aluRes = ~Rdst_value; updZN = 1'b1; end
      4'd2: begin aluRes = incSum[DATA_W-1:0];  cNext = incSum[DATA_W];  updZN = 1'b1; end
      4'd3: begin aluRes = decDiff[DATA_W-1:0]; cNext = decDiff[DATA_W]; updZN = 1'b1; end
      4'd4: begin aluRes = addSum[DATA_W-1:0];  cNext = addSum[DATA_W];  updZN = 1'b1; end
      4'd5: begin aluRes = subDiff[DATA_W-1:0]; cNext = subDiff[DATA_W]; updZN = 1'b1; end
      4'd6: begin aluRes = Rdst_value & Rsrc_value; updZN = 1'b1; end
      4'd7: begin aluRes = Rdst_value | Rsrc_value; updZN = 1'b1; end
      4'd8: begin
        aluRes = shlWide[DATA_W-1:0];
        updZN  = 1'b1;
        if (shAmt != 4'd0) cNext = shlWide[DATA_W];
      end
      4'd9: begin
        aluRes = shrWide[DATA_W:1];
        updZN  = 1'b1;
        if (shAmt != 4'd0) cNext = shrWide[0];
      end
      4'd10: aluRes = Rsrc_value;
      4'd11: cNext  = 1'b1;
      4'd12: cNext  = 1'b0;
      4'd13: aluRes = imm;
      default: aluRes = Rdst_value;
    endcase
    zNext = updZN ? (aluRes == '0) : zFlag;
    nNext = updZN ? aluRes[DATA_W-1] : nFlag;
  end

  // EX/MEM buffer, flags and interrupt push sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      EXMEM_ALU_result     <= '0;
      EXMEM_Rsrc_value     <= '0;
      EXMEM_Rdst_value     <= '0;
      EXMEM_Rdst_address   <= '0;
      EXMEM_memRead        <= 1'b0;
      EXMEM_memWrite       <= 1'b0;
      EXMEM_WB             <= 1'b0;
      EXMEM_push           <= 1'b0;
      EXMEM_pop            <= 1'b0;
      EXMEM_pc             <= '0;
      zFlag                <= 1'b0;
      nFlag                <= 1'b0;
      cFlag                <= 1'b0;
      intCounterValue      <= 2'b00;
      intSignalFromCounter <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Data is captured even on a flush; consumers ignore it because control is zeroed.
          EXMEM_ALU_result   <= aluRes;
          EXMEM_Rsrc_value   <= Rsrc_value;
          EXMEM_Rdst_value   <= Rdst_value;
          EXMEM_Rdst_address <= Rdst_address;
          if (flush) begin
            EXMEM_memRead  <= 1'b0;
            EXMEM_memWrite <= 1'b0;
            EXMEM_WB       <= 1'b0;
            EXMEM_push     <= 1'b0;
            EXMEM_pop      <= 1'b0;
          end else begin
            EXMEM_memRead  <= memRead;
            EXMEM_memWrite <= memWrite;
            EXMEM_WB       <= WB;
            EXMEM_push     <= push;
            EXMEM_pop      <= pop;
            zFlag          <= zNext;
            nFlag          <= nNext;
            cFlag          <= cNext;
          end
          if (irqTake) begin
            EXMEM_pc             <= pc_in + {{(PC_W-1){1'b0}}, 1'b1};
            state                <= PUSH_PCH;
            intCounterValue      <= 2'b01;
            intSignalFromCounter <= 1'b1;
          end
        end
        default: begin
          // Push slots: data operands and flags hold, memory stage writes the stack.
          EXMEM_memRead  <= 1'b0;
          EXMEM_memWrite <= 1'b1;
          EXMEM_WB       <= 1'b0;
          EXMEM_push     <= 1'b1;
          EXMEM_pop      <= 1'b0;
          case (state)
            PUSH_PCH: begin
              state           <= PUSH_PCL;
              intCounterValue <= 2'b10;
            end
            PUSH_PCL: begin
              state           <= PUSH_FLG;
              intCounterValue <= 2'b11;
            end
            default: begin
              state                <= IDLE;
              intCounterValue      <= 2'b00;
              intSignalFromCounter <= 1'b0;
            end
          endcase
        end
      endcase
    end
  end

endmodule
